riscv_ifetch: RTL and testbench

Instruction fetch unit for the RISC-V cpu. It is the initiator of the instruction-memory interface: it drives the fetch PC to the instruction memory and captures the returned instruction word. Fetched {pc, inst} pairs are buffered in a small FIFO and handed to the decode stage over a valid/ready handshake. The block also handles branch/jump redirects (with buffer flush) and misaligned-fetch faults.

---
 rtl/riscv_ifetch.sv | 114 +++++++++++
 tb/tb_riscv_ifetch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit: drives the fetch PC to instruction memory, buffers
// {pc, inst} pairs in a small FIFO for decode, and handles redirects and misaligned-fetch faults.
module riscv_ifetch #(
  parameter int                    PC_WIDTH   = 15,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  output logic                  id_valid,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [PC_WIDTH-1:0]   id_pc,
  input  logic                  id_ready,
  output logic                  fetch_fault,
  output logic [PC_WIDTH-1:0]   fault_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {FETCH, FAULT} state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  entry_t              fifo_mem [BUF_DEPTH];
  entry_t              head;

  logic pop, has_room, push, fault_set;

  assign imem_pc     = fetch_pc;
  assign id_valid    = (count != '0);
  assign fetch_fault = (state == FAULT);
  assign pop         = id_valid & id_ready;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign has_room    = (count < CNT_W'(BUF_DEPTH)) || pop;

  assign head    = fifo_mem[rd_ptr];
  assign id_pc   = id_valid ? head.pc   : '0;
  assign id_inst = id_valid ? head.inst : '0;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    fault_set     = 1'b0;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      state_next    = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (fetch_pc[1:0] != 2'b00) begin
            state_next = FAULT;
            fault_set  = 1'b1;
          end else if (has_room) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + PC_WIDTH'(4);
          end
        end
        FAULT: ;
        default: state_next = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fault_pc <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (fault_set) fault_pc <= fetch_pc;
      if (redirect_valid) begin
        // Flush: any pop offered this cycle is discarded along with the contents.
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: buffer storage is not reset; count gates id_valid so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{pc: fetch_pc, inst: imem_inst};
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: instruction memory returns word == pc,
// expected values are hand-computed per cycle.
module tb_riscv_ifetch;

  localparam int PW = 15;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [PW-1:0] imem_pc;
  logic [IW-1:0] imem_inst;
  logic          id_valid;
  logic [IW-1:0] id_inst;
  logic [PW-1:0] id_pc;
  logic          id_ready;
  logic          fetch_fault;
  logic [PW-1:0] fault_pc;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_ifetch #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC('0), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_inst(imem_inst),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory model: the word at each address equals the address.
  assign imem_inst = IW'(imem_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [PW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_imem_pc", 32'(imem_pc), 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_fault_pc", 32'(fault_pc), 32'h0);
    check("rst_id_pc", 32'(id_pc), 32'h0);
    check("rst_id_inst", id_inst, 32'h0);

    // Streaming with id_ready=1: one instruction per cycle
    step();
    check("start_valid", 32'(id_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream_pc%0d", i), 32'(id_pc), 32'(i * 4));
      check($sformatf("stream_inst%0d", i), id_inst, 32'(i * 4));
      check($sformatf("stream_valid%0d", i), 32'(id_valid), 32'd1);
      step();
    end

    // Backpressure: fill, stall, then drain without gaps
    do_reset();
    id_ready = 1'b0;
    step(6);
    check("stall_valid", 32'(id_valid), 32'd1);
    check("stall_id_pc", 32'(id_pc), 32'h0);
    check("stall_imem_pc", 32'(imem_pc), 32'h8);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_pc%0d", i), 32'(id_pc), 32'(i * 4));
      check($sformatf("drain_valid%0d", i), 32'(id_valid), 32'd1);
      step();
    end

    // Redirect with a full buffer and a simultaneous pop
    do_reset();
    id_ready = 1'b0;
    step(2);
    check("full_head", 32'(id_pc), 32'h0);
    id_ready = 1'b1;
    redirect(15'h100);
    check("redir_flush_valid", 32'(id_valid), 32'd0);
    check("redir_imem_pc", 32'(imem_pc), 32'h100);
    step();
    check("redir_valid", 32'(id_valid), 32'd1);
    check("redir_id_pc", 32'(id_pc), 32'h100);
    check("redir_id_inst", id_inst, 32'h100);
    step();
    check("redir_next_pc", 32'(id_pc), 32'h104);

    // Misaligned redirect target faults one cycle after the redirect
    redirect(15'h102);
    check("mis_n1_fault", 32'(fetch_fault), 32'd0);
    check("mis_n1_valid", 32'(id_valid), 32'd0);
    step();
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_fault_pc", 32'(fault_pc), 32'h102);
    check("mis_valid", 32'(id_valid), 32'd0);
    check("mis_imem_pc", 32'(imem_pc), 32'h102);
    step(3);
    check("mis_hold_fault", 32'(fetch_fault), 32'd1);
    check("mis_hold_imem", 32'(imem_pc), 32'h102);
    check("mis_hold_valid", 32'(id_valid), 32'd0);

    // Recovery redirect clears the fault
    redirect(15'h200);
    check("rec_fault", 32'(fetch_fault), 32'd0);
    check("rec_valid", 32'(id_valid), 32'd0);
    step();
    check("rec_valid2", 32'(id_valid), 32'd1);
    check("rec_id_pc", 32'(id_pc), 32'h200);

    // PC wraps modulo 2^PC_WIDTH
    redirect(15'h7FFC);
    step();
    check("wrap_pc0", 32'(id_pc), 32'h7FFC);
    check("wrap_imem", 32'(imem_pc), 32'h0);
    step();
    check("wrap_pc1", 32'(id_pc), 32'h0);
    check("wrap_valid", 32'(id_valid), 32'd1);

    // Reset with a full buffer
    redirect(15'h300);
    id_ready = 1'b0;
    step(3);
    check("pre_rst_full_pc", 32'(id_pc), 32'h300);
    check("pre_rst_full_imem", 32'(imem_pc), 32'h308);
    do_reset();
    check("rst_full_valid", 32'(id_valid), 32'd0);
    check("rst_full_imem", 32'(imem_pc), 32'h0);

    // Reset while faulted
    redirect(15'h6);
    step();
    check("pre_rst_fault", 32'(fetch_fault), 32'd1);
    check("pre_rst_fault_pc", 32'(fault_pc), 32'h6);
    do_reset();
    check("rst_fault_clr", 32'(fetch_fault), 32'd0);
    check("rst_fault_pc_clr", 32'(fault_pc), 32'h0);
    check("rst_fault_valid", 32'(id_valid), 32'd0);
    check("rst_fault_imem", 32'(imem_pc), 32'h0);
    id_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(id_valid), 32'd1);
    check("post_rst_pc", 32'(id_pc), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
